// File: rtl/fmult_accum_seq.sv
// Sequencer for the shared FMULT/ACCUM datapath: six zero-predictor terms, two pole terms,
// then captures SEZ and SE. Optional FMULT_ACCUM_SEQ_WREG_EN registers the W output.
module fmult_accum_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_wan,
  input  logic [15:0] i_s,
  output logic [2:0]  o_sel,
  output logic [15:0] o_w,
  output logic        o_acc_clear,
  output logic        o_busy,
  output logic        o_done,
  output logic [14:0] o_sez,
  output logic [14:0] o_se
);

  typedef enum logic [2:0] {
    StIdle,
    StZero,
    StCapZ,
    StPole,
    StCaps,
    StDone
`ifdef FMULT_ACCUM_SEQ_WREG_EN
    , StWaitZ,
    StWaitS
`endif
  } state_e;

  state_e      r_state;
  logic [2:0]  r_k;
  logic        r_done;
  logic [14:0] r_sez;
  logic [14:0] r_se;
  logic        w_term;
  logic        w_unused_s_lsb;

  assign w_unused_s_lsb = i_s[0];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_k     <= 3'd0;
      r_done  <= 1'b0;
      r_sez   <= 15'd0;
      r_se    <= 15'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_k     <= 3'd0;
            r_state <= StZero;
          end
        end
        StZero: begin
          r_k <= r_k + 3'd1;
          if (r_k == 3'd5) begin
`ifdef FMULT_ACCUM_SEQ_WREG_EN
            r_state <= StWaitZ;
`else
            r_state <= StCapZ;
`endif
          end
        end
        StCapZ: begin
          r_sez   <= i_s[15:1];
          r_k     <= 3'd6;
          r_state <= StPole;
        end
        StPole: begin
          // k wraps back to 0 after the last pole term
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) begin
`ifdef FMULT_ACCUM_SEQ_WREG_EN
            r_state <= StWaitS;
`else
            r_state <= StCaps;
`endif
          end
        end
        StCaps: begin
          r_se    <= i_s[15:1];
          r_done  <= 1'b1;
          r_state <= StDone;
        end
        StDone: r_state <= StIdle;
`ifdef FMULT_ACCUM_SEQ_WREG_EN
        StWaitZ: r_state <= StCapZ;
        StWaitS: r_state <= StCaps;
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_term      = (r_state == StZero) || (r_state == StPole);
  assign o_sel       = w_term ? r_k : 3'd0;
  assign o_acc_clear = (r_state == StIdle) || (r_state == StDone);
  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_sez       = r_sez;
  assign o_se        = r_se;

`ifdef FMULT_ACCUM_SEQ_WREG_EN
  logic [15:0] r_w;

  // One pipeline stage between FMULT and ACCUM; the wait states flush the last term.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_w <= 16'd0;
    end else begin
      r_w <= w_term ? i_wan : 16'd0;
    end
  end

  assign o_w = r_w;
`else
  assign o_w = w_term ? i_wan : 16'd0;
`endif

endmodule

// File: tb/tb_fmult_accum_seq.sv
// Bench for fmult_accum_seq: behavioural ACCUM and FMULT stand-ins, expected SEZ/SE queued
// at start and compared on done.
module tb_fmult_accum_seq;

`ifdef FMULT_ACCUM_SEQ_WREG_EN
  localparam int Lat = 13;
  localparam int P0  = 9;
`else
  localparam int Lat = 11;
  localparam int P0  = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] wan;
  logic [15:0] s;
  logic [2:0]  sel;
  logic [15:0] w;
  logic        acc_clear;
  logic        busy;
  logic        done;
  logic [14:0] sez;
  logic [14:0] se;

  int          checks = 0;
  int          errors = 0;
  int          mode   = 1;
  logic [29:0] scb[$];

  always #5 clk = ~clk;

  fmult_accum_seq dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_wan      (wan),
    .i_s        (s),
    .o_sel      (sel),
    .o_w        (w),
    .o_acc_clear(acc_clear),
    .o_busy     (busy),
    .o_done     (done),
    .o_sez      (sez),
    .o_se       (se)
  );

  function automatic logic [15:0] term(input int m, input int k);
    case (m)
      1:       return 16'h0001;
      2:       return 16'hFFFF;
      3:       return 16'h4000;
      default: return 16'(16'h0010 * (k + 1));
    endcase
  endfunction

  function automatic logic [29:0] expect_res(input int m);
    logic [15:0] sum6;
    logic [15:0] sum8;
    sum6 = 16'd0;
    for (int k = 0; k < 6; k++) sum6 = sum6 + term(m, k);
    sum8 = sum6 + term(m, 6) + term(m, 7);
    return {sum6[15:1], sum8[15:1]};
  endfunction

  // Stand-ins for the surrounding datapath
  always_comb wan = term(mode, int'(sel));

  always_ff @(posedge clk) begin
    if (acc_clear) s <= 16'd0;
    else           s <= s + w;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("done_has_expectation", 32'(scb.size() != 0), 32'd1);
      if (scb.size() != 0) begin
        logic [29:0] e;
        e = scb.pop_front();
        chk("sez", 32'(sez), 32'(e[29:15]));
        chk("se", 32'(se), 32'(e[14:0]));
      end
    end
  end

  task automatic run_single(input int m, input bit mid_pulse);
    mode  = m;
    start = 1'b1;
    scb.push_back(expect_res(m));
    step();
    start = 1'b0;
    for (int c = 1; c <= Lat + 2; c++) begin
      if (mid_pulse) start = (c == 4);
      chk("busy", 32'(busy), 32'(c <= Lat));
      chk("done_timing", 32'(done), 32'(c == Lat));
      if (c == 1)   chk("acc_clear_run", 32'(acc_clear), 32'd0);
      if (c == Lat) chk("acc_clear_done", 32'(acc_clear), 32'd1);
      if (m == 4 && c <= 6) chk("sel_zero", 32'(sel), 32'(c - 1));
      if (m == 4 && (c == P0 || c == P0 + 1)) chk("sel_pole", 32'(sel), 32'(6 + c - P0));
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_w", 32'(w), 32'd0);
    chk("rst_acc_clear", 32'(acc_clear), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sez", 32'(sez), 32'd0);
    chk("rst_se", 32'(se), 32'd0);
    step();

    run_single(1, 1'b0);
    run_single(2, 1'b0);
    run_single(3, 1'b0);
    run_single(4, 1'b0);
    run_single(1, 1'b1);

    // start held high: back-to-back runs
    mode  = 2;
    start = 1'b1;
    scb.push_back(expect_res(2));
    scb.push_back(expect_res(2));
    step();
    for (int c = 1; c <= 2 * Lat + 3; c++) begin
      if (c == Lat + 2) start = 1'b0;
      chk("held_busy", 32'(busy),
          32'((c <= Lat) || (c >= Lat + 2 && c <= 2 * Lat + 1)));
      chk("held_done", 32'(done), 32'(c == Lat || c == 2 * Lat + 1));
      if (c == Lat || c == Lat + 1) chk("held_acc_clear_hi", 32'(acc_clear), 32'd1);
      if (c == Lat + 2) chk("held_acc_clear_lo", 32'(acc_clear), 32'd0);
      step();
    end
    start = 1'b0;

    // reset in the middle of a run
    mode  = 3;
    start = 1'b1;
    scb.push_back(expect_res(3));
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    reset = 1'b0;
    void'(scb.pop_back());
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_acc_clear", 32'(acc_clear), 32'd1);
    chk("abort_sez", 32'(sez), 32'd0);
    chk("abort_se", 32'(se), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_w", 32'(w), 32'd0);
    reset = 1'b1;
    run_single(4, 1'b0);

    chk("scb_empty", 32'(scb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmult_accum_seq.md
# fmult_accum_seq

Sequencer that drives the single-resource FMULT/ACCUM datapath for one channel's predictor computation. On `start` it steps the shared FMULT through the six zero-predictor terms (B1·DQ1..B6·DQ6), then the two pole-predictor terms (A1·SR1, A2·SR2). It gates each product onto the ACCUM `W` input, controls ACCUM `clear`, and samples the running sum `S` to produce SEZ and SE. It is the initiator that feeds ACCUM, which accumulates `W` unconditionally whenever `clear` is low.

## Interface
- No parameters.
- `clk  input  1`: system clock; all state updates on its rising edge.
- `reset  input  1`: synchronous, active-low reset (0 = reset), sampled on `clk` rising edge.
- `start  input  1`: begin one channel computation; sampled only in IDLE.
- `wan  input  16`: product from FMULT for the term selected by `sel` (combinational FMULT, same cycle).
- `s  input  16`: ACCUM `S` output (running sum).
- `sel  output  3`: term index for the operand mux. 0–5 select Bk/DQk (k = sel+1); 6–7 select A1/SR1 and A2/SR2.
- `w  output  16`: to ACCUM `W`; equals `wan` during term cycles, 0 otherwise.
- `acc_clear  output  1`: to ACCUM `clear`.
- `busy  output  1`: high from the cycle after `start` is accepted through DONE inclusive.
- `done  output  1`: one-cycle pulse when `sez` and `se` are valid.
- `sez  output  15`: zero-predictor estimate, `s[15:1]` sampled after term 5.
- `se  output  15`: signal estimate, `s[15:1]` sampled after term 7.

## Operation
- States: IDLE, ZERO, CAPZ, POLE, CAPS, DONE; `WAITZ`/`WAITS` exist only with the macro.
- Term counter `k` is 3 bits; `sel = k` in ZERO/POLE, 0 elsewhere.
- **IDLE**
  - `acc_clear=1`, `w=0`.
  - When `start=1`: `k←0`, go to ZERO.
- **ZERO**
  - `acc_clear=0`, `w=wan`, `k` increments each cycle.
  - After `k=5`, go to CAPZ.
- **CAPZ**
  - `w=0`, `acc_clear=0`; `sez←s[15:1]`.
  - `k←6`, go to POLE.
- **POLE**
  - Same as ZERO for `k=6,7`, then go to CAPS.
- **CAPS**
  - `w=0`; `se←s[15:1]`; go to DONE.
- **DONE**
  - `done=1`, `acc_clear=1`, `w=0`; go to IDLE.
- Arithmetic
  - The sum is 16-bit two's complement and wraps modulo 2^16, as ACCUM does; no saturation.
  - SEZ/SE are the sum arithmetically shifted right by 1 with the LSB dropped; the 15 MSBs are kept, sign included.
- `sez`/`se` hold their value until the next capture.
- `start` outside IDLE is ignored and not queued. If `start` is held high, a new computation begins the cycle after DONE.
- Reset (`reset=0`) at any edge:
  - state→IDLE, `k=0`, `sel=0`, `w=0`, `acc_clear=1`, `busy=0`, `done=0`, `sez=0`, `se=0`.
  - No `done` is issued for an aborted computation.
  - ACCUM is cleared at the next edge via `acc_clear`.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1–6: ZERO (`sel` 0..5).
- Cycle 7: CAPZ; `s` holds the 6-term sum.
- Cycles 8–9: POLE.
- Cycle 10: CAPS.
- Cycle 11: DONE; `done=1`, and `sez`/`se` are already valid in this cycle.
- Latency from `start` sample to `done`: 11 cycles. Minimum start-to-start spacing: 12 cycles.
- `w`, `acc_clear` and `sel` are Moore outputs decoded from registered state. `sez`, `se` and `done` are registered.

## Configuration
- `FMULT_ACCUM_SEQ_WREG_EN`
  - Defined: `w` is registered (`w_q ← term-cycle ? wan : 0`), adding one pipeline stage between FMULT and ACCUM.
  - WAITZ is inserted between ZERO and CAPZ, and WAITS between POLE and CAPS. Each is one cycle with `w` source 0 and `acc_clear=0`.
  - `done` at cycle 13; minimum start spacing 14 cycles. Register `w_q` resets to 0.
  - Undefined: `w` is combinational, and timing is as above.
  - Numeric results are identical in both builds.

## Test plan
- `wan=0x0001` on every term, single `start`:
  - `sez=0x0003`, `se=0x0004`, `done` exactly at cycle 11, `busy` high cycles 1–11.
- `wan=0xFFFF` on every term:
  - sums 0xFFFA and 0xFFF8 give `sez=0x7FFD`, `se=0x7FFC` (i.e. −3, −4).
- `wan=0x4000` on every term (wrap):
  - 6-term sum 0x8000 gives `sez=0x4000`; 8-term sum 0x0000 gives `se=0x0000`.
- `wan` = 0x0010·(sel+1):
  - 6-term sum 0x0150 gives `sez=0x00A8`; 8-term sum 0x0240 gives `se=0x0120`.
  - `sel` sequence observed as 0,1,2,3,4,5,6,7.
- Pulse `start` at cycle 4, and hold `start` high continuously:
  - The mid-run pulse is ignored.
  - With `start` held, a second run begins at cycle 12 and its `done` comes at cycle 23.
  - `acc_clear=1` in cycles 11–12 boundary only as specified.
- `reset=0` at cycle 5 mid-run:
  - Next edge: `busy=0`, `acc_clear=1`, `sez=se=0`, and no `done`.
  - A fresh `start` afterwards gives correct results.
- With `FMULT_ACCUM_SEQ_WREG_EN` defined, rerun the first and third scenarios:
  - Same `sez`/`se` values, `done` at cycle 13.
